// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and defaults for the clock-switch sequencer.
// Optional lock wait is enabled by CLK_SWITCH_LOCK_CHECK_EN.
package crg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATE_OFF,
    WAIT_LOCK,
    SETTLE
  } clk_sw_state_e;

  localparam int CLK_SW_GATE_CYC_DEF = 4;
  localparam int CLK_SW_SEL_CYC_DEF  = 4;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Request/ready handshake plus mux/gate controls of the clock switch.
// Derives the select width from NUM_CLK.
interface clk_switch_ctrl_if #(
  parameter int NUM_CLK = 4
);
  localparam int SEL_W = $clog2(NUM_CLK);

  logic             req_valid_i;
  logic [SEL_W-1:0] req_sel_i;
  logic             req_ready_o;
  logic             en_i;
  logic [NUM_CLK-1:0] lock_i;
  logic [SEL_W-1:0] sel_o;
  logic             gate_en_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport master (
    output req_valid_i, req_sel_i, en_i, lock_i,
    input  req_ready_o, sel_o, gate_en_o,
    input  busy_o, done_o, err_o
  );

  modport slave (
    input  req_valid_i, req_sel_i, en_i, lock_i,
    output req_ready_o, sel_o, gate_en_o,
    output busy_o, done_o, err_o
  );

endinterface

// File: rtl/clk_switch_ctrl_down_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement.
// Decrement saturates at zero.
module crg_down_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Glitch-safe clock mux sequencer: gate off, wait, select, wait, gate on.
// CLK_SWITCH_LOCK_CHECK_EN adds a PLL-lock wait before the select change.
module clk_switch_ctrl
  import crg_pkg::*;
#(
  parameter int NUM_CLK  = 4,
  parameter int GATE_CYC = CLK_SW_GATE_CYC_DEF,
  parameter int SEL_CYC  = CLK_SW_SEL_CYC_DEF,
  parameter int RST_SEL  = 0
) (
  input logic             clk_i,
  input logic             rst_i,
  clk_switch_ctrl_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_CLK);
  localparam int CNT_W = $clog2(max2(GATE_CYC, SEL_CYC) + 1);
  localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_CLK);
  localparam logic [CNT_W-1:0] GATE_LD = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SEL_LD  = CNT_W'(SEL_CYC - 1);

  clk_sw_state_e    state, state_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic [SEL_W-1:0] tgt, tgt_n;
  logic             gate, gate_n;
  logic             done, done_n;
  logic             err, err_n;
  logic             load, dec, zero;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  crg_down_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (zero)
  );

`ifndef CLK_SWITCH_LOCK_CHECK_EN
  logic unused_lock;
  assign unused_lock = ^bus.lock_i;
`endif

  assign bus.req_ready_o = (state == IDLE);
  assign bus.busy_o      = (state != IDLE);
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    tgt_n    = tgt;
    gate_n   = gate;
    done_n   = 1'b0;
    err_n    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          tgt_n = bus.req_sel_i;
          if ({1'b0, bus.req_sel_i} >= NUM_L) begin
            err_n = 1'b1;
          end else if (bus.req_sel_i == sel) begin
            done_n = 1'b1;
          end else begin
            state_n  = GATE_OFF;
            gate_n   = 1'b0;
            load     = 1'b1;
            load_val = GATE_LD;
          end
        end else begin
          gate_n = bus.en_i;
        end
      end
      GATE_OFF: begin
        if (zero) begin
`ifdef CLK_SWITCH_LOCK_CHECK_EN
          state_n  = WAIT_LOCK;
`else
          sel_n    = tgt;
          load     = 1'b1;
          load_val = SEL_LD;
          state_n  = SETTLE;
`endif
        end else begin
          dec = 1'b1;
        end
      end
`ifdef CLK_SWITCH_LOCK_CHECK_EN
      WAIT_LOCK: begin
        if (bus.lock_i[tgt]) begin
          sel_n    = tgt;
          load     = 1'b1;
          load_val = SEL_LD;
          state_n  = SETTLE;
        end
      end
`endif
      SETTLE: begin
        if (zero) begin
          gate_n  = bus.en_i;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      sel   <= SEL_W'(RST_SEL);
      tgt   <= SEL_W'(RST_SEL);
      gate  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      tgt   <= tgt_n;
      gate  <= gate_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  assign bus.sel_o     = sel;
  assign bus.gate_en_o = gate;
  assign bus.done_o    = done;
  assign bus.err_o     = err;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed vector bench for clk_switch_ctrl (4-source and 3-source builds).
// Lock-wait sequence runs only with CLK_SWITCH_LOCK_CHECK_EN.
module tb_clk_switch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clk_switch_ctrl_if #(.NUM_CLK(4)) ifc ();
  clk_switch_ctrl_if #(.NUM_CLK(3)) ifc3 ();

  clk_switch_ctrl #(
    .NUM_CLK(4), .GATE_CYC(4), .SEL_CYC(4), .RST_SEL(0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  clk_switch_ctrl #(
    .NUM_CLK(3), .GATE_CYC(4), .SEL_CYC(4), .RST_SEL(0)
  ) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc3)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] s;
    logic       en;
    logic       rdy;
    logic [1:0] sel;
    logic       gate;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int pack4(int rdy, int sel, int gate,
                               int busy, int done, int err);
    return (rdy << 7) | (sel << 4) | (gate << 3) |
           (busy << 2) | (done << 1) | err;
  endfunction

  initial begin
    bit saw_done;
    //            rst v  s  en  rdy sel gate busy done err
    vecs[0]  = '{1, 0, 0, 1,  1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 1,  1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1,  1, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 1, 2, 1,  0, 0, 0, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 1,  0, 0, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 1,  0, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 1, 3, 1,  0, 0, 0, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 1,  0, 2, 0, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 0,  0, 2, 0, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0,  0, 2, 0, 1, 0, 0};
    vecs[10] = '{0, 0, 0, 0,  0, 2, 0, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 1,  1, 2, 1, 0, 1, 0};
    vecs[12] = '{0, 1, 2, 0,  1, 2, 1, 0, 1, 0};
    vecs[13] = '{0, 0, 0, 0,  1, 2, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 1,  1, 2, 1, 0, 0, 0};

    ifc.req_valid_i  = 1'b0;
    ifc.req_sel_i    = '0;
    ifc.en_i         = 1'b1;
    ifc.lock_i       = '1;
    ifc3.req_valid_i = 1'b0;
    ifc3.req_sel_i   = '0;
    ifc3.en_i        = 1'b1;
    ifc3.lock_i      = '1;
    #1;

`ifndef CLK_SWITCH_LOCK_CHECK_EN
    for (int i = 0; i < 15; i++) begin
      rst             = vecs[i].rst;
      ifc.req_valid_i = vecs[i].v;
      ifc.req_sel_i   = vecs[i].s;
      ifc.en_i        = vecs[i].en;
      tick();
      chk($sformatf("row%0d", i),
          pack4(int'(ifc.req_ready_o), int'(ifc.sel_o),
                int'(ifc.gate_en_o), int'(ifc.busy_o),
                int'(ifc.done_o), int'(ifc.err_o)),
          pack4(int'(vecs[i].rdy), int'(vecs[i].sel),
                int'(vecs[i].gate), int'(vecs[i].busy),
                int'(vecs[i].done), int'(vecs[i].err)));
    end
    ifc.req_valid_i = 1'b0;
    ifc.en_i        = 1'b1;
`else
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_gate", int'(ifc.gate_en_o), 1);
`endif

    // out-of-range request on the 3-source instance
    ifc3.req_valid_i = 1'b1;
    ifc3.req_sel_i   = 2'd3;
    tick();
    ifc3.req_valid_i = 1'b0;
    chk("err_pulse", int'(ifc3.err_o), 1);
    chk("err_sel", int'(ifc3.sel_o), 0);
    chk("err_rdy", int'(ifc3.req_ready_o), 1);
    chk("err_gate", int'(ifc3.gate_en_o), 1);
    tick();
    chk("err_clear", int'(ifc3.err_o), 0);

    // reset two cycles into GATE_OFF
    ifc.req_valid_i = 1'b1;
    ifc.req_sel_i   = 2'd3;
    tick();
    ifc.req_valid_i = 1'b0;
    tick();
    tick();
    chk("mid_busy", int'(ifc.busy_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_sel", int'(ifc.sel_o), 0);
    chk("rst_gate0", int'(ifc.gate_en_o), 0);
    chk("rst_rdy", int'(ifc.req_ready_o), 1);
    saw_done = ifc.done_o;
    for (int k = 0; k < 10; k++) begin
      tick();
      saw_done |= ifc.done_o;
      if (ifc.sel_o != 2'd0) saw_done = 1'b1;
    end
    chk("rst_nodone", int'(saw_done), 0);
    chk("rst_regate", int'(ifc.gate_en_o), 1);

`ifdef CLK_SWITCH_LOCK_CHECK_EN
    ifc.lock_i      = 4'b1101;
    ifc.req_valid_i = 1'b1;
    ifc.req_sel_i   = 2'd1;
    tick();
    ifc.req_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) chk("lk_sel4", int'(ifc.sel_o), 0);
    end
    chk("lk_sel10", int'(ifc.sel_o), 0);
    chk("lk_gate10", int'(ifc.gate_en_o), 0);
    ifc.lock_i = 4'b1111;
    tick();
    chk("lk_sel11", int'(ifc.sel_o), 1);
    chk("lk_busy11", int'(ifc.busy_o), 1);
    tick();
    tick();
    tick();
    chk("lk_nodone14", int'(ifc.done_o), 0);
    tick();
    chk("lk_done15", int'(ifc.done_o), 1);
    chk("lk_gate15", int'(ifc.gate_en_o), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
